// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate sweep sequencer.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Truth tables: bit i is the expected y for {a,b} == i.
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  // Settle wait is 0..255 cycles.
  localparam int SETTLE_CNT_W = $clog2(256);

endpackage

// File: rtl/gate_sweep_ctrl_if.sv
// Stimulus/result bundle between the sweep sequencer and its user.
interface gate_sweep_ctrl_if;
  logic       start;
  logic       abort;
  logic       y;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_mask;
  logic [1:0] vec_idx;

  modport master (
    output start, abort, y,
    input  a, b, busy, done, pass, fail_mask, vec_idx
  );

  modport slave (
    input  start, abort, y,
    output a, b, busy, done, pass, fail_mask, vec_idx
  );
endinterface

// File: rtl/gate_sweep_settle_cnt.sv
// Settle timer: counts up from 0 after a load, flags the last settle cycle.
module gate_sweep_settle_cnt
  import gate_sweep_pkg::*;
#(
  parameter int LAST = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [SETTLE_CNT_W-1:0] LAST_CNT = SETTLE_CNT_W'(LAST);

  logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;

  // Load wins over enable so every entry into SETTLE starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)    cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Clocked exhaustive checker for a 2-input gate: sweeps {a,b} 00..11,
// samples y after a settle delay and accumulates per-vector mismatches.
//
//   state  | meaning
//   IDLE   | a=b=0, results held, waiting for start
//   SETTLE | vector applied, waiting SETTLE_CYCLES cycles
//   SAMPLE | one cycle; y compared at the closing edge
//   DONE   | one cycle; done pulse, pass valid
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 1,
  parameter logic [3:0] TRUTH         = TT_NAND
) (
  input  logic              clk,
  input  logic              rst_n,
  gate_sweep_ctrl_if.slave  bus
);

  // With no settle time each vector goes straight to its sample cycle.
  localparam state_t FIRST_ST = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
  localparam int     LAST     = (SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1;

  state_t     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] mask_q, mask_d;
  logic       pass_q, pass_d;
  logic       a_q, b_q, busy_q, done_q;
  logic       busy_d, done_d;
  logic [1:0] ab_d;
  logic       settle_load, settle_en, settle_tc;

  gate_sweep_settle_cnt #(.LAST(LAST)) u_settle_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (settle_load),
    .en_i   (settle_en),
    .tc_o   (settle_tc)
  );

  // Next-state, scoreboard update, and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    mask_d  = mask_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          vec_d   = 2'd0;
          mask_d  = 4'd0;
          pass_d  = 1'b0;
          state_d = FIRST_ST;
        end
      end
      ST_SETTLE: begin
        if (bus.abort)      state_d = ST_IDLE;
        else if (settle_tc) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else begin
          // !== so that an undriven or X y counts as a mismatch.
          if (bus.y !== TRUTH[vec_q]) mask_d[vec_q] = 1'b1;
          if (vec_q == 2'd3) begin
            // pass is registered on the way into DONE so it is valid with done.
            pass_d  = ~|mask_d;
            state_d = ST_DONE;
          end else begin
            vec_d   = vec_q + 2'd1;
            state_d = FIRST_ST;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d      = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
    done_d      = (state_d == ST_DONE);
    ab_d        = busy_d ? vec_d : 2'b00;
    settle_load = (state_d == ST_SETTLE) && (state_q != ST_SETTLE);
    settle_en   = (state_q == ST_SETTLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= 2'd0;
      mask_q  <= 4'd0;
      pass_q  <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      mask_q  <= mask_d;
      pass_q  <= pass_d;
      a_q     <= ab_d[1];
      b_q     <= ab_d[0];
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_mask = mask_q;
  assign bus.vec_idx   = vec_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: three instances (S=1, S=0, S=3), each beside a
// behavioural gate whose function the bench selects per sweep.
module tb_gate_sweep_ctrl;
  import gate_sweep_pkg::*;

  localparam int G_NAND = 0, G_AND = 1, G_OR = 2, G_NOR = 3;
  localparam int G_XOR = 4, G_XNOR = 5, G_S0 = 6, G_S1 = 7;
  localparam int S_OF [3] = '{1, 0, 3};

  typedef struct {
    int         inst;
    int         mode;
    logic [3:0] mask;
  } vec_t;

  typedef struct {
    logic [3:0] mask;
    logic       pass;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int         mode_r [3] = '{G_NAND, G_NAND, G_NAND};
  logic [2:0] start_r = '0;
  logic [2:0] abort_r = '0;

  logic [2:0] busy_w, done_w, pass_w, a_w, b_w;
  logic [3:0] mask_w [3];
  logic [1:0] vec_w  [3];

  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t sb_q [$];

  function automatic logic gate_y(input int m, input logic a, input logic b);
    case (m)
      G_NAND:  return ~(a & b);
      G_AND:   return a & b;
      G_OR:    return a | b;
      G_NOR:   return ~(a | b);
      G_XOR:   return a ^ b;
      G_XNOR:  return ~(a ^ b);
      G_S1:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  gate_sweep_ctrl_if if0 ();
  gate_sweep_ctrl_if if1 ();
  gate_sweep_ctrl_if if2 ();

  gate_sweep_ctrl u_s1 (.clk(clk), .rst_n(rst_n), .bus(if0));
  gate_sweep_ctrl #(.SETTLE_CYCLES(0)) u_s0 (.clk(clk), .rst_n(rst_n), .bus(if1));
  gate_sweep_ctrl #(.SETTLE_CYCLES(3), .TRUTH(TT_NAND)) u_s3 (.clk(clk), .rst_n(rst_n), .bus(if2));

  assign {if0.start, if0.abort} = {start_r[0], abort_r[0]};
  assign {if1.start, if1.abort} = {start_r[1], abort_r[1]};
  assign {if2.start, if2.abort} = {start_r[2], abort_r[2]};
  assign if0.y = gate_y(mode_r[0], if0.a, if0.b);
  assign if1.y = gate_y(mode_r[1], if1.a, if1.b);
  assign if2.y = gate_y(mode_r[2], if2.a, if2.b);

  assign {busy_w[0], done_w[0], pass_w[0], a_w[0], b_w[0]} = {if0.busy, if0.done, if0.pass, if0.a, if0.b};
  assign {busy_w[1], done_w[1], pass_w[1], a_w[1], b_w[1]} = {if1.busy, if1.done, if1.pass, if1.a, if1.b};
  assign {busy_w[2], done_w[2], pass_w[2], a_w[2], b_w[2]} = {if2.busy, if2.done, if2.pass, if2.a, if2.b};
  assign mask_w[0] = if0.fail_mask;
  assign mask_w[1] = if1.fail_mask;
  assign mask_w[2] = if2.fail_mask;
  assign vec_w[0]  = if0.vec_idx;
  assign vec_w[1]  = if1.vec_idx;
  assign vec_w[2]  = if2.vec_idx;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input int i, input string tag);
    check($sformatf("%s_outs_%0d", tag, i),
          int'({busy_w[i], done_w[i], pass_w[i], a_w[i], b_w[i], mask_w[i], vec_w[i]}), 0);
  endtask

  // One full sweep; expected results go on the scoreboard at start and are
  // popped when done appears. n counts edges after the start-sampling edge.
  task automatic run_sweep(input int inst, input int mode, input logic [3:0] emask);
    exp_t e, g;
    int   n, bc, step, s;
    bit   got;
    s      = S_OF[inst];
    e.mask = emask;
    e.pass = (emask == 4'd0);
    e.lat  = 4 * (s + 1);
    sb_q.push_back(e);
    mode_r[inst]  = mode;
    start_r[inst] = 1'b1;
    tick();
    start_r[inst] = 1'b0;
    n = 0; bc = 0; got = 0;
    while (n <= 200) begin
      if (busy_w[inst]) begin
        bc++;
        step = n / (s + 1);
        check($sformatf("ab_i%0d_n%0d", inst, n), int'({a_w[inst], b_w[inst]}), step);
        check($sformatf("vec_i%0d_n%0d", inst, n), int'(vec_w[inst]), step);
      end
      if (done_w[inst]) begin
        got = 1;
        break;
      end
      tick();
      n++;
    end
    check($sformatf("done_seen_i%0d", inst), int'(got), 1);
    g = sb_q.pop_front();
    if (got) begin
      check($sformatf("done_lat_i%0d", inst), n, g.lat);
      check($sformatf("busy_cycles_i%0d", inst), bc, g.lat);
      check($sformatf("fail_mask_i%0d", inst), int'(mask_w[inst]), int'(g.mask));
      check($sformatf("pass_i%0d", inst), int'(pass_w[inst]), int'(g.pass));
    end
    tick();
    check($sformatf("idle_busy_i%0d", inst), int'(busy_w[inst]), 0);
    check($sformatf("idle_done_i%0d", inst), int'(done_w[inst]), 0);
    check($sformatf("hold_mask_i%0d", inst), int'(mask_w[inst]), int'(g.mask));
    check($sformatf("hold_pass_i%0d", inst), int'(pass_w[inst]), int'(g.pass));
  endtask

  initial begin
    vec_t tbl [8];
    int   rises, first_rise, second_rise, dones;
    logic prev;

    tbl = '{
      '{0, G_NAND, 4'b0000},
      '{1, G_S1,   4'b1000},
      '{2, G_XOR,  4'b0001},
      '{0, G_AND,  4'b1111},
      '{1, G_NOR,  4'b0110},
      '{2, G_NAND, 4'b0000},
      '{0, G_XNOR, 4'b1110},
      '{1, G_S0,   4'b0111}
    };

    tick();
    tick();
    for (int i = 0; i < 3; i++) check_reset_vals(i, "in_reset");
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) check_reset_vals(i, "after_reset");

    for (int k = 0; k < 8; k++) run_sweep(tbl[k].inst, tbl[k].mode, tbl[k].mask);

    // start held for 20 sampling edges: two sweeps, second accepted at +10.
    mode_r[0]  = G_NAND;
    start_r[0] = 1'b1;
    rises = 0; first_rise = -1; second_rise = -1; dones = 0; prev = 1'b0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (n == 19) start_r[0] = 1'b0;
      if (busy_w[0] && !prev) begin
        if (rises == 0) first_rise = n;
        else if (rises == 1) second_rise = n;
        rises++;
      end
      prev = busy_w[0];
      if (done_w[0]) dones++;
    end
    check("held_start_sweeps", rises, 2);
    check("held_start_first", first_rise, 0);
    check("held_start_second", second_rise, 10);
    check("held_start_dones", dones, 2);
    check("held_start_pass", int'(pass_w[0]), 1);

    // Abort during the settle cycle of vector 2 with y stuck at 0.
    mode_r[0]  = G_S0;
    start_r[0] = 1'b1;
    tick();
    start_r[0] = 1'b0;
    repeat (4) tick();
    check("abort_pre_vec", int'(vec_w[0]), 2);
    check("abort_pre_busy", int'(busy_w[0]), 1);
    abort_r[0] = 1'b1;
    tick();
    abort_r[0] = 1'b0;
    check("abort_busy", int'(busy_w[0]), 0);
    check("abort_ab", int'({a_w[0], b_w[0]}), 0);
    check("abort_mask", int'(mask_w[0]), 4'b0011);
    check("abort_pass", int'(pass_w[0]), 0);
    dones = 0;
    for (int n = 0; n < 12; n++) begin
      if (done_w[0]) dones++;
      tick();
    end
    check("abort_no_done", dones, 0);

    // start together with abort in IDLE is dropped; partial results survive.
    start_r[0] = 1'b1;
    abort_r[0] = 1'b1;
    tick();
    start_r[0] = 1'b0;
    abort_r[0] = 1'b0;
    check("start_abort_busy", int'(busy_w[0]), 0);
    tick();
    tick();
    check("start_abort_busy_later", int'(busy_w[0]), 0);
    check("start_abort_mask_kept", int'(mask_w[0]), 4'b0011);

    // Reset mid-sweep, then a clean sweep from vector 0.
    mode_r[0]  = G_S0;
    start_r[0] = 1'b1;
    tick();
    start_r[0] = 1'b0;
    repeat (3) tick();
    check("pre_reset_busy", int'(busy_w[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals(0, "midsweep_reset");
    tick();
    check_reset_vals(0, "held_reset");
    rst_n = 1'b1;
    tick();
    check_reset_vals(0, "post_reset");
    run_sweep(0, G_NAND, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
